// File: rtl/reg_file.sv
// Parametrised register file: one bit-masked write port, two registered read
// ports with write-to-read forwarding, and a clear sweep that zeroes every entry.
module reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH-1:0]         wmask,
  input  logic                     re_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  output logic [WIDTH-1:0]         rdata_a,
  input  logic                     re_b,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_b,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_addr;
  logic [AW-1:0]   w_clr_addr_nxt;
  logic            w_busy;
  logic            w_last;
  logic [WIDTH-1:0] w_wr_merged;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;
  logic            r_wr_drop;

  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_v,
                                               input logic [WIDTH-1:0] new_v,
                                               input logic [WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_busy      = (r_state == S_CLEAR);
  assign w_last      = (r_clr_addr == AW'(DEPTH - 1));
  assign w_wr_merged = f_merge(r_mem[waddr], wdata, wmask);

  // Control: state register and sweep counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // A clear request during a sweep is ignored; the counter wraps to 0 on the last entry.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_clr_addr_nxt = r_clr_addr + AW'(1);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage: sweep has priority over user writes, no direct reset of the array
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_busy)  r_mem[r_clr_addr] <= '0;
      else if (we) r_mem[waddr]      <= w_wr_merged;
    end
  end

  // Read stage: registered outputs with forwarding of the same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      if (re_a) begin
        if (w_busy)                     r_rdata_a <= '0;
        else if (we && raddr_a == waddr) r_rdata_a <= w_wr_merged;
        else                            r_rdata_a <= r_mem[raddr_a];
      end
      if (re_b) begin
        if (w_busy)                     r_rdata_b <= '0;
        else if (we && raddr_b == waddr) r_rdata_b <= w_wr_merged;
        else                            r_rdata_b <= r_mem[raddr_b];
      end
      r_wr_drop <= we && w_busy;
    end
  end

  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;
  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: 8x8 instance driven from a vector table plus
// multi-cycle sequences, and a 16-bit x 4 instance for the alternate geometry.
module tb_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, we, re_a, re_b;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, wmask, rdata_a, rdata_b;
  logic       busy, wr_drop;

  logic        reset16, clear16, we16, re_a16, re_b16;
  logic [1:0]  waddr16, raddr_a16, raddr_b16;
  logic [15:0] wdata16, wmask16, rdata_a16, rdata_b16;
  logic        busy16, wr_drop16;

  reg_file #(.WIDTH(8), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .re_a(re_a), .raddr_a(raddr_a),
    .rdata_a(rdata_a), .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .busy(busy), .wr_drop(wr_drop)
  );

  reg_file #(.WIDTH(16), .DEPTH(4)) u16 (
    .clk(clk), .reset(reset16), .clear(clear16), .we(we16), .waddr(waddr16),
    .wdata(wdata16), .wmask(wmask16), .re_a(re_a16), .raddr_a(raddr_a16),
    .rdata_a(rdata_a16), .re_b(re_b16), .raddr_b(raddr_b16), .rdata_b(rdata_b16),
    .busy(busy16), .wr_drop(wr_drop16)
  );

  typedef struct {
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [7:0] wmask;
    logic       re_a;
    logic [2:0] raddr_a;
    logic       re_b;
    logic [2:0] raddr_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                              input logic [7:0] wm, input logic ra, input logic [2:0] aa,
                              input logic rb, input logic [2:0] ab, input logic [7:0] ea,
                              input logic [7:0] eb, input logic ed);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.wmask = wm;
    v.re_a = ra; v.raddr_a = aa; v.re_b = rb; v.raddr_b = ab;
    v.exp_a = ea; v.exp_b = eb; v.exp_drop = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                     input logic [7:0] wm, input logic ra, input logic [2:0] aa,
                     input logic rb, input logic [2:0] ab, input logic clr);
    we = w; waddr = wa; wdata = wd; wmask = wm;
    re_a = ra; raddr_a = aa; re_b = rb; raddr_b = ab; clear = clr;
  endtask

  initial begin
    reset = 1'b1; reset16 = 1'b1;
    drv(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
    clear16 = 1'b0; we16 = 1'b0; waddr16 = '0; wdata16 = '0; wmask16 = '0;
    re_a16 = 1'b0; raddr_a16 = '0; re_b16 = 1'b0; raddr_b16 = '0;

    // Reset and power-up sweep
    tick();
    chk("rst_rdata_a", 16'(rdata_a), 16'h00);
    chk("rst_rdata_b", 16'(rdata_b), 16'h00);
    chk("rst_wr_drop", 16'(wr_drop), 16'h0);
    chk("rst_busy", 16'(busy), 16'h1);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      raddr_a = 3'(k); raddr_b = 3'(8 - k);
      tick();
      chk($sformatf("sweep_busy_%0d", k), 16'(busy), (k < 8) ? 16'h1 : 16'h0);
      chk($sformatf("sweep_rd_a_%0d", k), 16'(rdata_a), 16'h00);
      chk($sformatf("sweep_rd_b_%0d", k), 16'(rdata_b), 16'h00);
    end

    // Vector table
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i), 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 3'd3, 8'hA5, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 3'd3, 8'h0F, 8'h0F, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3, 8'hAF, 8'hAF, 1'b0));
    vecs.push_back(mk(1'b1, 3'd5, 8'h11, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 8'hAF, 8'hAF, 1'b0));
    vecs.push_back(mk(1'b1, 3'd5, 8'hF0, 8'hF0, 1'b1, 3'd5, 1'b1, 3'd5, 8'hF1, 8'hF1, 1'b0));
    vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd5, 1'b1, 3'd3, 8'hF1, 8'hAF, 1'b0));
    vecs.push_back(mk(1'b1, 3'd1, 8'h55, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 8'h00, 8'hAF, 1'b0));
    vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b1, 3'd1, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 3'd6, 8'h3C, 8'hFF, 1'b1, 3'd5, 1'b1, 3'd6, 8'hF1, 8'h3C, 1'b0));
    vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd6, 1'b1, 3'd5, 8'h3C, 8'hF1, 1'b0));
    foreach (vecs[i]) begin
      drv(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask, vecs[i].re_a,
          vecs[i].raddr_a, vecs[i].re_b, vecs[i].raddr_b, 1'b0);
      tick();
      chk($sformatf("vec%0d_rd_a", i), 16'(rdata_a), 16'(vecs[i].exp_a));
      chk($sformatf("vec%0d_rd_b", i), 16'(rdata_b), 16'(vecs[i].exp_b));
      chk($sformatf("vec%0d_drop", i), 16'(wr_drop), 16'(vecs[i].exp_drop));
      chk($sformatf("vec%0d_busy", i), 16'(busy), 16'h0);
    end

    // Clear during traffic, with dropped writes and an ignored second clear
    for (int a = 0; a < 8; a++) begin
      drv(1'b1, 3'(a), 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    drv(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd2, 1'b1, 3'd7, 1'b0);
    tick();
    chk("fill_rd_a", 16'(rdata_a), 16'hFF);
    chk("fill_rd_b", 16'(rdata_b), 16'hFF);
    drv(1'b1, 3'd2, 8'h12, 8'hFF, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1);
    tick();
    chk("clr_busy", 16'(busy), 16'h1);
    chk("clr_fwd_a", 16'(rdata_a), 16'h12);
    chk("clr_drop", 16'(wr_drop), 16'h0);
    for (int k = 1; k <= 8; k++) begin
      drv((k == 1 || k == 3 || k == 4), 3'd4, 8'h77, 8'hFF, 1'b1, 3'(k - 1), 1'b1, 3'd2, (k == 5));
      tick();
      chk($sformatf("clr%0d_busy", k), 16'(busy), (k < 8) ? 16'h1 : 16'h0);
      chk($sformatf("clr%0d_drop", k), 16'(wr_drop), (k == 1 || k == 3 || k == 4) ? 16'h1 : 16'h0);
      chk($sformatf("clr%0d_rd_a", k), 16'(rdata_a), 16'h00);
      chk($sformatf("clr%0d_rd_b", k), 16'(rdata_b), 16'h00);
    end
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0);
      tick();
      chk($sformatf("post_clr_rd_a_%0d", i), 16'(rdata_a), 16'h00);
      chk($sformatf("post_clr_rd_b_%0d", i), 16'(rdata_b), 16'h00);
    end

    // Hold, then reset in the middle of a sweep
    drv(1'b1, 3'd0, 8'h3C, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    chk("hold_load", 16'(rdata_a), 16'h3C);
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 3'd0, 8'h99, 8'hFF, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0);
      tick();
      chk($sformatf("hold%0d_rd_a", k), 16'(rdata_a), 16'h3C);
      chk($sformatf("hold%0d_rd_b", k), 16'(rdata_b), 16'h99);
    end
    drv(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid%0d_busy", k), 16'(busy), 16'h1);
      chk($sformatf("mid%0d_rd_a", k), 16'(rdata_a), 16'h3C);
    end
    reset = 1'b1; we = 1'b1;
    tick();
    chk("mid_rst_rd_a", 16'(rdata_a), 16'h00);
    chk("mid_rst_drop", 16'(wr_drop), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h1);
    reset = 1'b0; we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("restart%0d_busy", k), 16'(busy), (k < 8) ? 16'h1 : 16'h0);
    end

    // 16-bit x 4 instance
    tick();
    reset16 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("w16_sweep%0d_busy", k), 16'(busy16), (k < 4) ? 16'h1 : 16'h0);
    end
    we16 = 1'b1; waddr16 = 2'd3; wdata16 = 16'hBEEF; wmask16 = 16'hFFFF;
    tick();
    we16 = 1'b0; re_a16 = 1'b1; raddr_a16 = 2'd3; re_b16 = 1'b1; raddr_b16 = 2'd2;
    tick();
    chk("w16_rd_a", rdata_a16, 16'hBEEF);
    chk("w16_rd_b", rdata_b16, 16'h0000);
    re_a16 = 1'b0; re_b16 = 1'b0; clear16 = 1'b1;
    tick();
    chk("w16_clr_busy", 16'(busy16), 16'h1);
    clear16 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("w16_clr%0d_busy", k), 16'(busy16), (k < 4) ? 16'h1 : 16'h0);
    end
    re_a16 = 1'b1; raddr_a16 = 2'd3;
    tick();
    chk("w16_post_clr_rd_a", rdata_a16, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
